// File: rtl/mems_dac_spi_if.sv
// +--------------------------------------------------------------------------+
// | mems_dac_spi_if : start/data handshake and SPI pins of the MEMS DAC link  |
// | Optional ldac_n pin with MEMS_SPI_LDAC_EN.            Revision: 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mems_dac_spi_if #(
  parameter int WORD_BITS = 24
);
  logic                 start;
  logic [WORD_BITS-1:0] data_in;
  logic                 busy;
  logic                 sclk;
  logic                 mosi;
  logic                 sync_n;
  logic                 word_done;
`ifdef MEMS_SPI_LDAC_EN
  logic                 ldac_n;
`endif

  // master: the serialiser itself
  modport master (
    input  start, data_in,
    output busy, sclk, mosi, sync_n,
`ifdef MEMS_SPI_LDAC_EN
    output ldac_n,
`endif
    output word_done
  );

  // slave: the controller / DAC side
  modport slave (
    output start, data_in,
    input  busy, sclk, mosi, sync_n,
`ifdef MEMS_SPI_LDAC_EN
    input  ldac_n,
`endif
    input  word_done
  );
endinterface

`default_nettype wire

// File: rtl/mems_dac_spi_master.sv
// +--------------------------------------------------------------------------+
// | mems_dac_spi_master : one DAC command word per start pulse, MSB first,    |
// | sclk idle high; optional LDAC strobe with MEMS_SPI_LDAC_EN. Revision: 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mems_dac_spi_master #(
  parameter int WORD_BITS = 24,
  parameter int CLK_DIV   = 2,
  parameter int ROM_LAT   = 1,
  parameter int SYNC_GAP  = 2
) (
  input  wire               clk,
  input  wire               rst,
  mems_dac_spi_if.master    bus
);

`ifdef MEMS_SPI_LDAC_EN
  // the gap must cover the whole ldac_n low pulse plus one settling cycle
  localparam int c_gap_len = (SYNC_GAP > CLK_DIV + 1) ? SYNC_GAP : CLK_DIV + 1;
`else
  localparam int c_gap_len = SYNC_GAP;
`endif

  localparam int c_cnt_max = (ROM_LAT > CLK_DIV)
                           ? ((ROM_LAT > c_gap_len) ? ROM_LAT : c_gap_len)
                           : ((CLK_DIV > c_gap_len) ? CLK_DIV : c_gap_len);
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_bit_w   = $clog2(WORD_BITS);

  localparam logic [c_cnt_w-1:0] c_lat_last = c_cnt_w'(ROM_LAT - 1);
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(c_gap_len - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WORD_BITS - 1);
  localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [c_bit_w-1:0]   bit_q, bit_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic                 busy_q, busy_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 sync_n_q, sync_n_d;
  logic                 word_done_q, word_done_d;
  logic                 ldac_n_q, ldac_n_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    busy_d      = busy_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    sync_n_d    = sync_n_q;
    word_done_d = 1'b0;
    ldac_n_d    = ldac_n_q;

    case (state_q)
      ST_IDLE: begin
        // the word_done cycle still counts as busy for the controller
        if (bus.start && !word_done_q) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          bit_d  = '0;
          if (ROM_LAT == 0) begin
            shreg_d  = bus.data_in;
            mosi_d   = bus.data_in[WORD_BITS-1];
            sync_n_d = 1'b0;
            sclk_d   = 1'b1;
            state_d  = ST_SHIFT;
          end else begin
            state_d  = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q == c_lat_last) begin
          shreg_d  = bus.data_in;
          mosi_d   = bus.data_in[WORD_BITS-1];
          sync_n_d = 1'b0;
          sclk_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == c_div_last) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == c_bit_last) begin
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
            ldac_n_d = 1'b0;
            state_d  = ST_GAP;
          end else begin
            // rotate keeps the next bit at the top; mosi only moves with sclk rising
            sclk_d  = 1'b1;
            bit_d   = bit_q + c_bit_one;
            shreg_d = {shreg_q[WORD_BITS-2:0], shreg_q[WORD_BITS-1]};
            mosi_d  = shreg_q[WORD_BITS-2];
          end
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      ST_GAP: begin
        if (cnt_q == c_div_last) begin
          ldac_n_d = 1'b1;
        end
        if (cnt_q == c_gap_last) begin
          cnt_d       = '0;
          busy_d      = 1'b0;
          word_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      sync_n_q    <= 1'b1;
      word_done_q <= 1'b0;
      ldac_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      busy_q      <= busy_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      sync_n_q    <= sync_n_d;
      word_done_q <= word_done_d;
      ldac_n_q    <= ldac_n_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.sclk      = sclk_q;
  assign bus.mosi      = mosi_q;
  assign bus.sync_n    = sync_n_q;
  assign bus.word_done = word_done_q;
`ifdef MEMS_SPI_LDAC_EN
  assign bus.ldac_n    = ldac_n_q;
`else
  // direct mode: the DAC updates on sync_n rising, no strobe leaves the block
  logic unused_ldac;
  assign unused_ldac = ldac_n_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mems_dac_spi_master.sv
// +--------------------------------------------------------------------------+
// | tb_mems_dac_spi_master : directed vectors for the MEMS DAC SPI master     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mems_dac_spi_master;
  localparam int WORD_BITS = 24;
  localparam int CLK_DIV   = 2;
  localparam int ROM_LAT   = 1;
  localparam int SYNC_GAP  = 2;
`ifdef MEMS_SPI_LDAC_EN
  localparam int c_busy_exp = 100;  // 1 + 96 + max(2, 3)
`else
  localparam int c_busy_exp = 99;   // 1 + 96 + 2
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mems_dac_spi_if #(.WORD_BITS(WORD_BITS)) bus ();

  mems_dac_spi_master #(
    .WORD_BITS (WORD_BITS),
    .CLK_DIV   (CLK_DIV),
    .ROM_LAT   (ROM_LAT),
    .SYNC_GAP  (SYNC_GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DAC-side observer: samples mid-cycle, away from the active edge
  int          fall_tot  = 0;
  int          busy_tot  = 0;
  int          wd_tot    = 0;
  int          frame_tot = 0;
  int          hi_run    = 0;
  int          ldac_tot  = 0;
  int          ldac_hits = 0;
  int          gaps [0:15];
  logic [23:0] rx_sh     = '0;
  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b1;

  always @(negedge clk) begin
    if (prev_sclk === 1'b1 && bus.sclk === 1'b0 && bus.sync_n === 1'b0) begin
      fall_tot++;
      rx_sh = {rx_sh[22:0], bus.mosi};
    end
    if (bus.busy === 1'b1) busy_tot++;
    if (bus.word_done === 1'b1) wd_tot++;
    if (prev_sync === 1'b1 && bus.sync_n === 1'b0) begin
      if (frame_tot < 16) gaps[frame_tot] = hi_run;
      frame_tot++;
      hi_run = 0;
    end
    if (bus.sync_n === 1'b1) hi_run++;
`ifdef MEMS_SPI_LDAC_EN
    if (bus.ldac_n === 1'b0) ldac_tot++;
    if (prev_sync === 1'b0 && bus.sync_n === 1'b1 && bus.ldac_n === 1'b0) ldac_hits++;
`endif
    prev_sclk = bus.sclk;
    prev_sync = bus.sync_n;
  end

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.word_done !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_in_time"}, 32'(n < 300), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int f0, b0, w0, fr0, l0, h0, n;
    bus.start   = 1'b0;
    bus.data_in = '0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // idle after reset: {busy, sclk, sync_n, mosi, word_done}
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("reset_idle", {bus.busy, bus.sclk, bus.sync_n, bus.mosi, bus.word_done}, 5'b01100);
`ifdef MEMS_SPI_LDAC_EN
      check("reset_ldac", bus.ldac_n, 1);
`endif
    end

    // single word, data_in changed after it has been loaded
    bus.data_in = 24'hA53C81;
    bus.start   = 1'b1;
    f0 = fall_tot; b0 = busy_tot; w0 = wd_tot; l0 = ldac_tot; h0 = ldac_hits;
    @(posedge clk); #1 bus.start = 1'b0;
    check("w1_busy_rise", bus.busy, 1);
    repeat (4) @(posedge clk);
    #1 bus.data_in = 24'h000000;
    wait_done("w1");
    check("w1_busy_low_at_done", bus.busy, 0);

    // start held through the word_done cycle is ignored, the next cycle accepted
    bus.data_in = 24'h5AC37E;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    check("start_in_done_ignored", bus.busy, 0);
    check("w1_done_single", bus.word_done, 0);
    check("w1_bits", rx_sh, 24'hA53C81);
    check("w1_falls", fall_tot - f0, 24);
    check("w1_busy_clks", busy_tot - b0, c_busy_exp);
    check("w1_done_pulses", wd_tot - w0, 1);
`ifdef MEMS_SPI_LDAC_EN
    check("w1_ldac_low_clks", ldac_tot - l0, 2);
    check("w1_ldac_at_sync_rise", ldac_hits - h0, 1);
`endif
    f0 = fall_tot; b0 = busy_tot; w0 = wd_tot;
    @(posedge clk); #1 bus.start = 1'b0;
    check("b2b_busy_rise", bus.busy, 1);
    wait_done("w2");
    repeat (3) @(posedge clk); #1;
    check("w2_bits", rx_sh, 24'h5AC37E);
    check("w2_falls", fall_tot - f0, 24);
    check("w2_busy_clks", busy_tot - b0, c_busy_exp);
    check("w2_done_pulses", wd_tot - w0, 1);

    // start held for 300 clocks
    repeat (5) @(posedge clk); #1;
    fr0 = frame_tot; w0 = wd_tot;
    bus.data_in = 24'hC0FFEE;
    bus.start   = 1'b1;
    repeat (300) @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    while ((bus.busy === 1'b1 || bus.word_done === 1'b1) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("stream_drained", 32'(n < 400), 1);
    repeat (3) @(posedge clk); #1;
    check("stream_frames", frame_tot - fr0, 3);
    check("stream_done_pulses", wd_tot - w0, 3);
    check("stream_gap1", 32'(gaps[fr0 + 1] >= SYNC_GAP), 1);
    check("stream_gap2", 32'(gaps[fr0 + 2] >= SYNC_GAP), 1);
    check("stream_last_bits", rx_sh, 24'hC0FFEE);

    // reset 40 clocks into a transfer
    bus.data_in = 24'h0F0F0F;
    bus.start   = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", {bus.busy, bus.sclk, bus.sync_n, bus.mosi, bus.word_done}, 5'b01100);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    bus.data_in = 24'h123456;
    bus.start   = 1'b1;
    f0 = fall_tot; b0 = busy_tot; w0 = wd_tot;
    @(posedge clk); #1 bus.start = 1'b0;
    check("w3_busy_rise", bus.busy, 1);
    wait_done("w3");
    repeat (3) @(posedge clk); #1;
    check("w3_bits", rx_sh, 24'h123456);
    check("w3_falls", fall_tot - f0, 24);
    check("w3_busy_clks", busy_tot - b0, c_busy_exp);
    check("w3_done_pulses", wd_tot - w0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
